hazcon: RTL and testbench
=========================

HAZCON -- requirements
Module: hazcon

Interface
REQ-001 SHALL have parameter MC_LAT, default 4: total EX-stage occupancy in cycles of a multi-cycle op; legal range 3..16.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 idex_memr  in  1  the ID/EX instruction is a load.
REQ-006 idex_rd  in  5  ID/EX destination register.
REQ-007 ifid_rs1, ifid_rs2  in  5 each  IF/ID source registers.
REQ-008 ifid_rs2_use  in  1  the IF/ID instruction reads rs2.
REQ-009 idex_mc  in  1  the ID/EX instruction is a multi-cycle op.
REQ-010 branch_taken  in  1  a taken branch is resolved in EX this cycle.
REQ-011 pc_wr, ifid_wr, idex_wr  out  1 each  pipeline register write enables.
REQ-012 idex_bubble, ifid_flush, exmem_bubble  out  1 each  insert NOP into ID/EX, clear IF/ID, insert NOP into EX/MEM.
REQ-013 busy  out  1  high when state is not RUN.

Function
REQ-014 SHALL hold a registered state in {RUN, MCWAIT, MCDONE} and a 4-bit down-counter cnt.
REQ-015 All outputs SHALL be combinational from state and inputs, with zero latency to the detecting cycle.
REQ-016 Load-use hazard (lu) SHALL be: idex_memr & idex_rd!=0 & (idex_rd==ifid_rs1 | (ifid_rs2_use & idex_rd==ifid_rs2)).
REQ-017 Default outputs: pc_wr=ifid_wr=idex_wr=1; idex_bubble=ifid_flush=exmem_bubble=0.
REQ-018 RUN with branch_taken: ifid_flush=1, idex_bubble=1, writes enabled; lu and idex_mc ignored; state stays RUN. Branch has highest priority.
REQ-019 RUN with idex_mc and no branch_taken: pc_wr=ifid_wr=idex_wr=0, exmem_bubble=1; cnt<=MC_LAT-3; next state MCWAIT. idex_mc has priority over lu.
REQ-020 RUN with lu only: pc_wr=ifid_wr=0, idex_bubble=1, idex_wr=1, for exactly that cycle; state stays RUN.
REQ-021 MCWAIT: pc_wr=ifid_wr=idex_wr=0, exmem_bubble=1; branch_taken and lu ignored.
REQ-022 MCWAIT transitions: if cnt==0, next state MCDONE; else cnt<=cnt-1.
REQ-023 MCDONE: idex_mc ignored; branch_taken and lu evaluated as in RUN; next state RUN unconditionally.
REQ-024 A multi-cycle op SHALL occupy EX for exactly MC_LAT cycles: 1 detect cycle, MC_LAT-2 MCWAIT cycles, 1 MCDONE cycle.
REQ-025 Back-to-back multi-cycle ops SHALL be handled: idex_mc re-asserted in the RUN cycle after MCDONE starts a new sequence.

Reset
REQ-026 rstn low SHALL immediately force state=RUN and cnt=0, including mid-MCWAIT. All outputs then take their REQ-017 defaults unless inputs dictate otherwise.
REQ-027 The first rising clk edge after rstn deasserts SHALL evaluate normally.

Configuration
REQ-028 With HAZCON_STATS_EN defined, the block SHALL add outputs ldstall_cnt and mcstall_cnt, out, 16 bits each.
REQ-029 ldstall_cnt SHALL increment on each cycle where REQ-020 applies.
REQ-030 mcstall_cnt SHALL increment on each cycle with exmem_bubble=1.
REQ-031 Both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-032 Without HAZCON_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Load-use: idex_memr=1, idex_rd=5, ifid_rs1=5 -> one cycle of pc_wr=0, ifid_wr=0, idex_bubble=1. Same with idex_rd=0 -> no stall.
REQ-034 rs2 qualification: idex_rd=7=ifid_rs2 with ifid_rs2_use=0 -> no stall; with ifid_rs2_use=1 -> stall.
REQ-035 MC_LAT=4, idex_mc held 1 -> exmem_bubble=1 for 3 cycles; busy high for 3 cycles (MCWAIT x2, MCDONE x1); RUN on cycle 5.
REQ-036 Simultaneous branch_taken=1, idex_mc=1, lu true in RUN -> ifid_flush=1, idex_bubble=1, state stays RUN.
REQ-037 rstn pulsed low during the second MCWAIT cycle -> busy=0 and all writes enabled immediately; ldstall_cnt=mcstall_cnt=0 when HAZCON_STATS_EN is defined.
REQ-038 With HAZCON_STATS_EN, 70000 forced lu cycles -> ldstall_cnt=16'hFFFF.

Source files
------------

// File: rtl/hazcon.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and multi-cycle EX stall.
// Latency: all controls are combinational from state and inputs in the detecting cycle.
// Backpressure: freezes PC/IF/ID (and ID/EX during multi-cycle ops); HAZCON_STATS_EN adds stall counters.
module hazcon #(
  parameter int MC_LAT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       idex_memr,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_rs2_use,
  input  logic       idex_mc,
  input  logic       branch_taken,
  output logic       pc_wr,
  output logic       ifid_wr,
  output logic       idex_wr,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       exmem_bubble,
  output logic       busy
`ifdef HAZCON_STATS_EN
  ,
  output logic [15:0] ldstall_cnt,
  output logic [15:0] mcstall_cnt
`endif
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] MCWAIT = 2'd1;
  localparam logic [1:0] MCDONE = 2'd2;

  // The detect cycle and the MCDONE cycle are not part of the wait count,
  // so the counter is loaded with MC_LAT-3 and MCWAIT lasts MC_LAT-2 cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MC_LAT - 3);

  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lu;
  logic       ld_stall;

  assign lu = idex_memr && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs1) || (ifid_rs2_use && (idex_rd == ifid_rs2)));

  assign busy = (state != RUN);

  // Output decode and next-state selection; branch beats multi-cycle beats load-use.
  always_comb begin
    pc_wr        = 1'b1;
    ifid_wr      = 1'b1;
    idex_wr      = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    exmem_bubble = 1'b0;
    ld_stall     = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    case (state)
      MCWAIT: begin
        pc_wr        = 1'b0;
        ifid_wr      = 1'b0;
        idex_wr      = 1'b0;
        exmem_bubble = 1'b1;
        if (cnt == 4'd0) state_nxt = MCDONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        // RUN and MCDONE share decode; MCDONE ignores idex_mc and always
        // returns to RUN. Unused encodings also fall back to RUN.
        state_nxt = RUN;
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if ((state == RUN) && idex_mc) begin
          pc_wr        = 1'b0;
          ifid_wr      = 1'b0;
          idex_wr      = 1'b0;
          exmem_bubble = 1'b1;
          cnt_nxt      = CNT_LOAD;
          state_nxt    = MCWAIT;
        end else if (lu) begin
          pc_wr       = 1'b0;
          ifid_wr     = 1'b0;
          idex_bubble = 1'b1;
          ld_stall    = 1'b1;
        end
      end
    endcase
  end

  // State and wait counter; reset lands in RUN even mid-sequence.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZCON_STATS_EN
  // Saturating counts of load-use stall cycles and EX/MEM bubble cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ldstall_cnt <= 16'd0;
      mcstall_cnt <= 16'd0;
    end else begin
      if (ld_stall && (ldstall_cnt != 16'hFFFF))     ldstall_cnt <= ldstall_cnt + 16'd1;
      if (exmem_bubble && (mcstall_cnt != 16'hFFFF)) mcstall_cnt <= mcstall_cnt + 16'd1;
    end
  end
`else
  logic unused_ld_stall;
  assign unused_ld_stall = ld_stall;
`endif

endmodule

// File: tb/tb_hazcon.sv
module tb_hazcon;
  localparam int MC_LAT = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       idex_memr;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       ifid_rs2_use, idex_mc, branch_taken;
  logic       pc_wr, ifid_wr, idex_wr, idex_bubble, ifid_flush, exmem_bubble, busy;
`ifdef HAZCON_STATS_EN
  logic [15:0] ldstall_cnt, mcstall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: cycles of EX occupancy still owed after the current one
  int rem = 0;
  int m_ld = 0;
  int m_mc = 0;

  hazcon #(.MC_LAT(MC_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .idex_memr(idex_memr), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rs2_use(ifid_rs2_use),
    .idex_mc(idex_mc), .branch_taken(branch_taken),
    .pc_wr(pc_wr), .ifid_wr(ifid_wr), .idex_wr(idex_wr),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .exmem_bubble(exmem_bubble), .busy(busy)
`ifdef HAZCON_STATS_EN
    , .ldstall_cnt(ldstall_cnt), .mcstall_cnt(mcstall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // output vector order: {pc_wr, ifid_wr, idex_wr, idex_bubble, ifid_flush, exmem_bubble, busy}
  function automatic logic [6:0] outs();
    return {pc_wr, ifid_wr, idex_wr, idex_bubble, ifid_flush, exmem_bubble, busy};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Entered at posedge+1: drive inputs, sample at negedge, advance model, return at next posedge+1.
  task automatic cycle(input logic memr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic use2, input logic mc, input logic br,
                       input bit do_chk, output logic [6:0] got, output logic [6:0] expv);
    logic l, lust;
    idex_memr = memr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    ifid_rs2_use = use2; idex_mc = mc; branch_taken = br;
    @(negedge clk);
    got  = outs();
    l    = memr && (rd != 0) && (rd == rs1 || (use2 && rd == rs2));
    lust = 1'b0;
    expv = 7'b1110000;
    if (rem > 1) expv = 7'b0000011;
    else begin
      if (br)                 expv = 7'b1111100;
      else if (rem == 0 && mc) expv = 7'b0000010;
      else if (l) begin expv = 7'b0011000; lust = 1'b1; end
      if (rem == 1) expv[0] = 1'b1;
    end
`ifdef HAZCON_STATS_EN
    if (do_chk) begin
      check("ldstall_cnt", ldstall_cnt, 16'(m_ld));
      check("mcstall_cnt", mcstall_cnt, 16'(m_mc));
    end
`endif
    if (lust && m_ld < 65535) m_ld++;
    if (expv[1] && m_mc < 65535) m_mc++;
    if (rem == 0 && mc && !br) rem = MC_LAT - 1;
    else if (rem > 0) rem--;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       memr;
    logic [4:0] rd, rs1, rs2;
    logic       use2, mc, br;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];
  logic [6:0] g, e;
  logic [6:0] exb_seq, busy_seq;

  initial begin
    rstn = 1'b0;
    idex_memr = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    ifid_rs2_use = 0; idex_mc = 0; branch_taken = 0;

    tbl.push_back('{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 7'b1110000, "idle"});
    tbl.push_back('{1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 7'b0011000, "lu_rs1"});
    tbl.push_back('{1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 7'b1110000, "lu_rd0"});
    tbl.push_back('{1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 7'b1110000, "rs2_nouse"});
    tbl.push_back('{1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 7'b0011000, "rs2_use"});
    tbl.push_back('{0, 5'd5, 5'd5, 5'd5, 1, 0, 0, 7'b1110000, "no_load"});
    tbl.push_back('{1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 7'b1111100, "br_mc_lu"});
    tbl.push_back('{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 7'b1110000, "after_br"});
    tbl.push_back('{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 7'b1111100, "branch"});
    tbl.push_back('{1, 5'd9, 5'd9, 5'd9, 1, 0, 0, 7'b0011000, "lu_both"});

    // reset state while rstn held low
    @(posedge clk); #1;
    check("reset_outs", 16'(outs()), 16'(7'b1110000));
`ifdef HAZCON_STATS_EN
    check("reset_ld", ldstall_cnt, 16'd0);
    check("reset_mc", mcstall_cnt, 16'd0);
`endif
    rstn = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].memr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].use2,
            tbl[i].mc, tbl[i].br, 1'b1, g, e);
      check({"tbl_", tbl[i].name}, 16'(g), 16'(tbl[i].exp));
    end

    // idex_mc held: bubbles on cycles 1-3, busy on 2-4, new sequence on cycle 5
    exb_seq  = 7'b0010111;
    busy_seq = 7'b0001110;
    for (int c = 0; c < 5; c++) begin
      cycle(0, 0, 0, 0, 0, 1, 0, 1'b1, g, e);
      check($sformatf("mc_exb_c%0d", c + 1), 16'(g[1]), 16'(exb_seq[c]));
      check($sformatf("mc_busy_c%0d", c + 1), 16'(g[0]), 16'(busy_seq[c]));
    end
    for (int c = 0; c < 5; c++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 1'b1, g, e);
      check("mc_drain", 16'(g), 16'(e));
    end

    // MCDONE: idex_mc ignored, load-use still stalls
    cycle(0, 0, 0, 0, 0, 1, 0, 1'b1, g, e);
    cycle(0, 0, 0, 0, 0, 0, 0, 1'b1, g, e);
    cycle(0, 0, 0, 0, 0, 0, 0, 1'b1, g, e);
    cycle(1, 5'd4, 5'd4, 5'd0, 0, 1, 0, 1'b1, g, e);
    check("mcdone_lu", 16'(g), 16'(7'b0011001));
    cycle(0, 0, 0, 0, 0, 0, 0, 1'b1, g, e);
    check("mcdone_to_run", 16'(g), 16'(7'b1110000));

    // reset pulsed during the second MCWAIT cycle
    cycle(0, 0, 0, 0, 0, 1, 0, 1'b1, g, e);
    cycle(0, 0, 0, 0, 0, 0, 0, 1'b1, g, e);
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_outs", 16'(outs()), 16'(7'b1110000));
`ifdef HAZCON_STATS_EN
    check("rst_mid_ld", ldstall_cnt, 16'd0);
    check("rst_mid_mc", mcstall_cnt, 16'd0);
`endif
    rem = 0; m_ld = 0; m_mc = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    cycle(0, 0, 0, 0, 0, 1, 0, 1'b1, g, e);
    check("post_rst_detect", 16'(g), 16'(7'b0000010));
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 0, 0, 0, 1'b1, g, e);
    check("post_rst_mcdone", 16'(g), 16'(7'b1110001));

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 1'b1, g, e);
      check("rand", 16'(g), 16'(e));
    end

`ifdef HAZCON_STATS_EN
    // saturation of the load-use counter
    for (int n = 0; n < 4; n++) cycle(0, 0, 0, 0, 0, 0, 0, 1'b1, g, e);
    for (int n = 0; n < 70000; n++) cycle(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1'b0, g, e);
    check("ld_saturate", ldstall_cnt, 16'hFFFF);
    cycle(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1'b1, g, e);
    check("ld_sat_hold", ldstall_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
